// File: rtl/nonce_flag_encoder.sv
// Purpose : round-robin 32-to-5 encoder that turns one-cycle nonce-found pulses into held grants.
// Latency : req pulse -> pending after 1 edge -> grant_valid after the next edge (2 cycles when idle).
// Backpr. : grant held stable until grant_ready; new pulses accumulate in pending, none are dropped.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   req[31:0]             per-core event pulses
//   clear                 synchronous flush of pending events and any in-flight grant
//   grant_ready           readout controller accepts the current grant
//   grant_valid           grant_index / grant_onehot are valid
//   grant_index[4:0]      index of the granted core
//   grant_onehot[31:0]    one-hot of grant_index, zero while grant_valid is low
//   pending[31:0]         registered pending-event vector
module nonce_flag_encoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] req,
  input  logic        clear,
  input  logic        grant_ready,
  output logic        grant_valid,
  output logic [4:0]  grant_index,
  output logic [31:0] grant_onehot,
  output logic [31:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  ptr, ptr_nxt;
  logic [4:0]  index_nxt;
  logic [31:0] pending_nxt;
  logic [31:0] ack;
  logic [4:0]  sel_idx;
  logic        sel_found;

  // Outputs are decoded only from registered state, so onehot cannot glitch
  // relative to grant_valid.
  assign grant_valid  = (state == GRANT);
  assign grant_onehot = grant_valid ? (32'd1 << grant_index) : 32'd0;

  // First set pending bit scanning ptr, ptr+1, ... with 5-bit wrap.
  always_comb begin
    logic [4:0] cand;
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int i = 0; i < 32; i++) begin
      cand = ptr + 5'(i);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    index_nxt = grant_index;
    ack       = 32'd0;

    case (state)
      IDLE: begin
        if (sel_found) begin
          index_nxt = sel_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ack       = grant_onehot;
          ptr_nxt   = grant_index + 5'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new pulse on the bit being acknowledged survives: req is OR-ed in
    // after the ack mask would have cleared it... so mask only the old value.
    pending_nxt = (pending & ~ack) | req;

    // Flush wins over everything, including a same-cycle handshake.
    if (clear) begin
      pending_nxt = 32'd0;
      ptr_nxt     = 5'd0;
      state_nxt   = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= 5'd0;
      grant_index <= 5'd0;
      pending     <= 32'd0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_index <= index_nxt;
      pending     <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_nonce_flag_encoder.sv
module tb_nonce_flag_encoder;

  logic        clock;
  logic        reset_n;
  logic [31:0] req;
  logic        clear;
  logic        grant_ready;
  logic        grant_valid;
  logic [4:0]  grant_index;
  logic [31:0] grant_onehot;
  logic [31:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  nonce_flag_encoder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .clear        (clear),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot),
    .pending      (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it before sampling or driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Async reset pulse placed between edges.
  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  // Check a granted state: valid, index and its one-hot.
  task automatic chk_grant(input string tag, input int idx);
    logic [31:0] oh;
    oh = 32'd1 << idx;
    chk({tag, "_vld"}, 32'(grant_valid), 32'd1);
    chk({tag, "_idx"}, 32'(grant_index), 32'(idx));
    chk({tag, "_oh"},  grant_onehot, oh);
  endtask

  initial begin
    reset_n     = 1'b0;
    req         = 32'd0;
    clear       = 1'b0;
    grant_ready = 1'b0;
    #12;
    chk("rst_vld", 32'(grant_valid), 32'd0);
    chk("rst_idx", 32'(grant_index), 32'd0);
    chk("rst_oh",  grant_onehot, 32'd0);
    chk("rst_pend", pending, 32'd0);
    reset_n = 1'b1;
    tick();

    // ---- async reset mid-GRANT ----
    req = 32'h0000_1000;
    tick();
    req = 32'd0;
    tick();
    chk_grant("ar_pre", 12);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_vld",  32'(grant_valid), 32'd0);
    chk("ar_idx",  32'(grant_index), 32'd0);
    chk("ar_oh",   grant_onehot, 32'd0);
    chk("ar_pend", pending, 32'd0);
    #1 reset_n = 1'b1;
    tick();
    tick();
    chk("ar_post_vld", 32'(grant_valid), 32'd0);

    // ---- single event ----
    req = 32'h0000_0080;
    tick();
    req = 32'd0;
    chk("se_pend", pending, 32'h0000_0080);
    chk("se_vld0", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("se", 7);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("se_pend2", pending, 32'd0);
    chk("se_ptr", 32'(dut.ptr), 32'd8);
    chk("se_vld1", 32'(grant_valid), 32'd0);

    // ---- wrap-around ----
    pulse_reset();
    tick();
    req = 32'h8000_0001;
    tick();
    req = 32'd0;
    tick();
    chk_grant("wr0", 0);
    grant_ready = 1'b1;
    tick();
    chk("wr_ptr1", 32'(dut.ptr), 32'd1);
    tick();
    chk_grant("wr1", 31);
    tick();
    grant_ready = 1'b0;
    chk("wr_ptr0", 32'(dut.ptr), 32'd0);
    chk("wr_pend", pending, 32'd0);

    // ---- round-robin fairness: reach ptr=6 by granting 5 first ----
    req = 32'h0000_0020;
    tick();
    req = 32'd0;
    tick();
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("rr_ptr6", 32'(dut.ptr), 32'd6);
    req = 32'h0000_0228;  // bits 3, 5, 9
    tick();
    req = 32'd0;
    tick();
    chk_grant("rr9", 9);
    grant_ready = 1'b1;
    tick();
    tick();
    chk_grant("rr3", 3);
    tick();
    tick();
    chk_grant("rr5", 5);
    tick();
    grant_ready = 1'b0;
    chk("rr_ptr_end", 32'(dut.ptr), 32'd6);
    chk("rr_pend", pending, 32'd0);

    // ---- backpressure and collision ----
    req = 32'h0000_0010;
    tick();
    req = 32'd0;
    tick();
    chk_grant("bp_start", 4);
    for (int c = 0; c < 10; c++) begin
      req = (c == 2) ? 32'h0000_0004 : (c == 5) ? 32'h0000_0010 : 32'd0;
      tick();
      chk("bp_hold_idx", 32'(grant_index), 32'd4);
      chk("bp_hold_vld", 32'(grant_valid), 32'd1);
    end
    req = 32'd0;
    chk("bp_pend_held", pending, 32'h0000_0014);
    // Accept with a fresh pulse on bit 4 in the same cycle.
    grant_ready = 1'b1;
    req = 32'h0000_0010;
    tick();
    req = 32'd0;
    chk("bp_coll_pend", pending, 32'h0000_0014);
    chk("bp_ptr5", 32'(dut.ptr), 32'd5);
    // ptr=5: scan 5..31,0,1,2 reaches bit 2 before bit 4.
    tick();
    chk_grant("bp_g2", 2);
    tick();
    tick();
    chk_grant("bp_g4", 4);
    tick();
    grant_ready = 1'b0;
    chk("bp_pend_end", pending, 32'd0);

    // ---- clear ----
    req = 32'h00F0_0000;
    tick();
    req = 32'd0;
    tick();
    chk_grant("cl_pre", 20);
    chk("cl_pre_pend", pending, 32'h00F0_0000);
    clear       = 1'b1;
    req         = 32'h0000_0001;
    grant_ready = 1'b1;
    tick();
    clear       = 1'b0;
    req         = 32'd0;
    grant_ready = 1'b0;
    chk("cl_pend", pending, 32'd0);
    chk("cl_vld", 32'(grant_valid), 32'd0);
    chk("cl_oh", grant_onehot, 32'd0);
    chk("cl_ptr", 32'(dut.ptr), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("cl_quiet_vld", 32'(grant_valid), 32'd0);
    end
    chk("cl_quiet_pend", pending, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
